vscale_fetch: RTL and testbench
===============================

VSCALE_FETCH -- requirements
Module: vscale_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h00000200, PC loaded into PC_IF by reset.
REQ-002 Parameter: NOP_INST, 32'h00000013, instruction injected into DX on kill (ADDI x0,x0,0).
REQ-003 The clock and reset ports SHALL be: clk input 1 (clock, all state on rising edge); reset input 1 (synchronous, active-high).
REQ-004 The select and target inputs SHALL be:
- PC_src_sel input 3: next-PC select. 0=PLUS_FOUR, 1=BRANCH_TARGET, 2=JAL_TARGET, 3=REG_TARGET, 4=REPLAY, 5=HANDLER.
- branch_target input 32: branch target PC.
- jal_target input 32: JAL target PC.
- reg_target input 32: JALR computed address.
- handler_PC input 32: trap vector.
REQ-005 The pipeline-control inputs SHALL be: stall_IF, kill_IF, stall_DX, kill_DX, each input 1, pipeline control from the control unit.
REQ-006 The instruction-memory ports SHALL be:
- imem_addr output 32: fetch address.
- imem_wait input 1: memory busy, data not valid.
- imem_rdata input 32: instruction returned for the previous cycle's imem_addr.
REQ-007 The fetch-state outputs SHALL be:
- PC_IF output 32: PC of the instruction currently in IF.
- PC_DX output 32: PC of the instruction in DX.
- inst_DX output 32: instruction presented to decode.

Function
REQ-008 Next-PC (PC_PIF) SHALL be combinational from PC_src_sel:
- 0: PC_IF+4, modulo 2^32 (wraps 32'hFFFFFFFC to 0).
- 1: branch_target.
- 2: jal_target.
- 3: {reg_target[31:1],1'b0}.
- 4: PC_IF.
- 5: handler_PC.
- 6 and 7: PC_IF+4.
REQ-009 imem_addr SHALL equal PC_IF when stall_IF=1, else PC_PIF; instruction data returns one cycle after the address.
REQ-010 PC_IF SHALL load PC_PIF on a rising edge when stall_IF=0 and hold otherwise.
REQ-011 A selection of 5 (HANDLER) SHALL load PC_IF even when stall_IF=1.
REQ-012 The DX register SHALL hold PC_DX and inst_DX unchanged while stall_DX=1.
REQ-013 When stall_DX=0 and kill_IF=1, the DX register SHALL load PC_DX<=PC_IF and inst_DX<=NOP_INST.
REQ-014 When stall_DX=0 and kill_IF=0, the DX register SHALL load PC_DX<=PC_IF and inst_DX<=fetched instruction (REQ-022, else imem_rdata).
REQ-015 When stall_DX=0 and kill_DX=1, the DX load SHALL still occur; kill_DX only gates the skid buffer (REQ-021).
REQ-016 Latency SHALL be one cycle from PC_IF update to DX capture, with no wait states when imem_wait=0.
REQ-017 When imem_wait=1 with stall_DX=0, kill_IF SHALL be asserted by control and the block SHALL insert NOP_INST per cycle; no special handling is required beyond REQ-013.
REQ-018 A redirect (PC_src_sel in 1,2,3,5) coincident with imem_wait=1 SHALL still advance PC_IF to the target; the stale response is discarded through kill_IF and REPLAY refetches it.

Reset
REQ-019 Reset SHALL set PC_IF=RESET_PC, PC_DX=RESET_PC, inst_DX=NOP_INST, and skid valid=0 (when present).
REQ-020 Reset SHALL override all other inputs, including mid-stall and mid-redirect, and imem_addr during reset SHALL equal PC_PIF computed from the reset-valued PC_IF.

Configuration
REQ-021 Macro VSCALE_FETCH_SKID_EN defined SHALL add a one-entry skid buffer (skid_valid, skid_inst):
- Set: on imem_wait=0, stall_DX=1, kill_DX=0, skid_valid=0, and PC_src_sel in {0,4}, skid_inst<=imem_rdata.
- Clear: on DX load (stall_DX=0), on PC_src_sel in {1,2,3,5}, or on reset.
- Set and clear in the same cycle: clear SHALL win.
REQ-022 With the macro defined and skid_valid=1, a DX load with kill_IF=0 SHALL take skid_inst instead of imem_rdata, even if imem_wait=1.
REQ-023 With the macro undefined there SHALL be no skid state; a stalled instruction is refetched from the held imem_addr, and all other behaviour is identical.

Verification
REQ-024 Reset with RESET_PC=32'h200: PC_IF=32'h200, inst_DX=32'h00000013, and imem_addr=32'h204 with PC_src_sel=0.
REQ-025 Sequential fetch, imem_rdata=32'h00500093 at PC 32'h200, then a clock: inst_DX=32'h00500093, PC_DX=32'h200, PC_IF=32'h204.
REQ-026 PC_src_sel=3, reg_target=32'h00000301: imem_addr=32'h300, and PC_IF=32'h300 after the edge.
REQ-027 stall_IF=stall_DX=1 for 3 cycles with PC_IF=32'h210: imem_addr=32'h210 and PC_DX/inst_DX unchanged throughout.
REQ-028 PC_src_sel=5, handler_PC=32'h100, stall_IF=1: PC_IF=32'h100 next cycle, and skid_valid=0 when VSCALE_FETCH_SKID_EN is defined.
REQ-029 VSCALE_FETCH_SKID_EN defined, rdata 32'h00A00113 returned during stall_DX=1, imem_wait=1 when the stall releases: inst_DX=32'h00A00113.

Source files
------------

// File: rtl/vscale_fetch_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
// The fetch stage drives the address; memory returns data one cycle later
// and raises imem_wait while that data is not valid.
interface vscale_fetch_if;
    logic [31:0] imem_addr;
    logic        imem_wait;
    logic [31:0] imem_rdata;

    modport master (
        output imem_addr,
        input  imem_wait,
        input  imem_rdata
    );

    modport slave (
        input  imem_addr,
        output imem_wait,
        output imem_rdata
    );
endinterface

// File: rtl/vscale_fetch.sv
// vscale_fetch: instruction fetch stage (IF) and IF->DX pipeline register.
// Selects the next PC, drives the instruction-memory address, and hands
// the fetched instruction (or a NOP on kill) to decode.
// Optional feature: define VSCALE_FETCH_SKID_EN to add a one-entry skid
// buffer that captures a response which arrives while DX is stalled.
module vscale_fetch #(
    parameter logic [31:0] RESET_PC = 32'h00000200,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [2:0]             PC_src_sel,
    input  logic [31:0]            branch_target,
    input  logic [31:0]            jal_target,
    input  logic [31:0]            reg_target,
    input  logic [31:0]            handler_PC,
    input  logic                   stall_IF,
    input  logic                   kill_IF,
    input  logic                   stall_DX,
    input  logic                   kill_DX,
    vscale_fetch_if.master         imem,
    output logic [31:0]            PC_IF,
    output logic [31:0]            PC_DX,
    output logic [31:0]            inst_DX
);

    localparam logic [2:0] SEL_PLUS_FOUR = 3'd0;
    localparam logic [2:0] SEL_BRANCH    = 3'd1;
    localparam logic [2:0] SEL_JAL       = 3'd2;
    localparam logic [2:0] SEL_REG       = 3'd3;
    localparam logic [2:0] SEL_REPLAY    = 3'd4;
    localparam logic [2:0] SEL_HANDLER   = 3'd5;

    logic [31:0] pc_pif_s;
    logic [31:0] fetched_inst_s;
    logic        redirect_s;

    // Next-PC mux; unused encodings fall back to sequential fetch.
    always_comb begin
        pc_pif_s = PC_IF + 32'd4;
        case (PC_src_sel)
            SEL_PLUS_FOUR: pc_pif_s = PC_IF + 32'd4;
            SEL_BRANCH:    pc_pif_s = branch_target;
            SEL_JAL:       pc_pif_s = jal_target;
            SEL_REG:       pc_pif_s = {reg_target[31:1], 1'b0};
            SEL_REPLAY:    pc_pif_s = PC_IF;
            SEL_HANDLER:   pc_pif_s = handler_PC;
            default:       pc_pif_s = PC_IF + 32'd4;
        endcase
    end

    // Redirects discard any buffered sequential response.
    always_comb begin
        redirect_s = 1'b0;
        if ((PC_src_sel == SEL_BRANCH) || (PC_src_sel == SEL_JAL) ||
            (PC_src_sel == SEL_REG) || (PC_src_sel == SEL_HANDLER)) begin
            redirect_s = 1'b1;
        end else begin
            redirect_s = 1'b0;
        end
    end

    // Memory address: hold the current PC while IF is stalled.
    always_comb begin
        if (stall_IF) begin
            imem.imem_addr = PC_IF;
        end else begin
            imem.imem_addr = pc_pif_s;
        end
    end

    // IF PC register; a trap handler entry overrides an IF stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            PC_IF <= RESET_PC;
        end else if (!stall_IF || (PC_src_sel == SEL_HANDLER)) begin
            PC_IF <= pc_pif_s;
        end else begin
            PC_IF <= PC_IF;
        end
    end

`ifdef VSCALE_FETCH_SKID_EN
    logic        skid_valid_r;
    logic [31:0] skid_inst_r;

    // Skid buffer: capture a valid sequential response while DX is stalled;
    // any DX load or redirect empties it, and clearing beats capturing.
    always_ff @(posedge clk) begin
        if (reset || !stall_DX || redirect_s) begin
            skid_valid_r <= 1'b0;
            skid_inst_r  <= skid_inst_r;
        end else if (!imem.imem_wait && !kill_DX && !skid_valid_r) begin
            skid_valid_r <= 1'b1;
            skid_inst_r  <= imem.imem_rdata;
        end else begin
            skid_valid_r <= skid_valid_r;
            skid_inst_r  <= skid_inst_r;
        end
    end

    // A buffered instruction takes priority over the live memory response.
    always_comb begin
        if (skid_valid_r) begin
            fetched_inst_s = skid_inst_r;
        end else begin
            fetched_inst_s = imem.imem_rdata;
        end
    end
`else
    // Without a skid buffer the instruction always comes straight from memory.
    always_comb begin
        fetched_inst_s = imem.imem_rdata;
    end
`endif

    // IF->DX register: hold on stall, inject a NOP on kill_IF.
    always_ff @(posedge clk) begin
        if (reset) begin
            PC_DX   <= RESET_PC;
            inst_DX <= NOP_INST;
        end else if (!stall_DX) begin
            PC_DX <= PC_IF;
            if (kill_IF) begin
                inst_DX <= NOP_INST;
            end else begin
                inst_DX <= fetched_inst_s;
            end
        end else begin
            PC_DX   <= PC_DX;
            inst_DX <= inst_DX;
        end
    end

endmodule

// File: tb/tb_vscale_fetch.sv
// Self-checking bench for vscale_fetch: directed literal checks followed by
// randomized stimulus compared every cycle against a behavioural model.
module tb_vscale_fetch;

    localparam logic [31:0] RESET_PC = 32'h00000200;
    localparam logic [31:0] NOP      = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  PC_src_sel;
    logic [31:0] branch_target, jal_target, reg_target, handler_PC;
    logic        stall_IF, kill_IF, stall_DX, kill_DX;
    logic [31:0] PC_IF, PC_DX, inst_DX;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    vscale_fetch_if imem ();

    vscale_fetch #(.RESET_PC(RESET_PC), .NOP_INST(NOP)) dut (
        .clk(clk), .reset(reset), .PC_src_sel(PC_src_sel),
        .branch_target(branch_target), .jal_target(jal_target),
        .reg_target(reg_target), .handler_PC(handler_PC),
        .stall_IF(stall_IF), .kill_IF(kill_IF),
        .stall_DX(stall_DX), .kill_DX(kill_DX),
        .imem(imem.master),
        .PC_IF(PC_IF), .PC_DX(PC_DX), .inst_DX(inst_DX)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc_if, m_pc_dx, m_inst_dx;
    bit          m_skid_v;
    logic [31:0] m_skid_inst;

    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        case (PC_src_sel)
            3'd1:    return branch_target;
            3'd2:    return jal_target;
            3'd3:    return reg_target & 32'hFFFF_FFFE;
            3'd4:    return pc;
            3'd5:    return handler_PC;
            default: return pc + 32'd4;
        endcase
    endfunction

    function automatic bit is_redirect();
        return (PC_src_sel inside {3'd1, 3'd2, 3'd3, 3'd5});
    endfunction

    // Model advance on each rising edge from the inputs of that cycle.
    always @(posedge clk) begin
        logic [31:0] npc, fetched;
        bit          nsv;
        logic [31:0] nsi;
        npc = next_pc(m_pc_if);
        fetched = imem.imem_rdata;
        nsv = m_skid_v;
        nsi = m_skid_inst;
`ifdef VSCALE_FETCH_SKID_EN
        if (m_skid_v) fetched = m_skid_inst;
        if (!stall_DX || is_redirect()) nsv = 1'b0;
        else if (!imem.imem_wait && !kill_DX && !m_skid_v) begin
            nsv = 1'b1;
            nsi = imem.imem_rdata;
        end
`endif
        if (reset) begin
            m_pc_if = RESET_PC; m_pc_dx = RESET_PC; m_inst_dx = NOP; m_skid_v = 1'b0;
        end else begin
            if (!stall_DX) begin
                m_pc_dx   = m_pc_if;
                m_inst_dx = kill_IF ? NOP : fetched;
            end
            if (!stall_IF || PC_src_sel == 3'd5) m_pc_if = npc;
            m_skid_v = nsv;
            m_skid_inst = nsi;
        end
    end

    // Compare process: every cycle once reset has been applied.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_imem_addr", imem.imem_addr, stall_IF ? m_pc_if : next_pc(m_pc_if));
            chk("model_PC_IF", PC_IF, m_pc_if);
            chk("model_PC_DX", PC_DX, m_pc_dx);
            chk("model_inst_DX", inst_DX, m_inst_dx);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; PC_src_sel = 3'd0;
        branch_target = 32'd0; jal_target = 32'd0; reg_target = 32'd0; handler_PC = 32'd0;
        stall_IF = 1'b0; kill_IF = 1'b0; stall_DX = 1'b0; kill_DX = 1'b0;
        imem.imem_wait = 1'b0; imem.imem_rdata = 32'd0;
        step(); step();
        chk_en = 1'b1;

        // Reset values and the first fetch address.
        #1;
        chk("rst_PC_IF", PC_IF, 32'h00000200);
        chk("rst_PC_DX", PC_DX, 32'h00000200);
        chk("rst_inst_DX", inst_DX, 32'h00000013);
        chk("rst_imem_addr", imem.imem_addr, 32'h00000204);

        // Sequential fetch.
        reset = 1'b0; imem.imem_rdata = 32'h00500093;
        step();
        chk("seq_inst_DX", inst_DX, 32'h00500093);
        chk("seq_PC_DX", PC_DX, 32'h00000200);
        chk("seq_PC_IF", PC_IF, 32'h00000204);

        // JALR target clears bit 0.
        PC_src_sel = 3'd3; reg_target = 32'h00000301; imem.imem_rdata = 32'h00000000;
        #1;
        chk("jalr_imem_addr", imem.imem_addr, 32'h00000300);
        step();
        chk("jalr_PC_IF", PC_IF, 32'h00000300);

        // Branch to 0x210, then stall IF and DX for three cycles.
        PC_src_sel = 3'd1; branch_target = 32'h00000210; imem.imem_rdata = 32'h00C00193;
        step();
        chk("br_PC_IF", PC_IF, 32'h00000210);
        PC_src_sel = 3'd0; stall_IF = 1'b1; stall_DX = 1'b1;
        for (int i = 0; i < 3; i++) begin
            imem.imem_rdata = $urandom;
            #1;
            chk("stall_imem_addr", imem.imem_addr, 32'h00000210);
            step();
            chk("stall_PC_IF", PC_IF, 32'h00000210);
            chk("stall_PC_DX", PC_DX, 32'h00000300);
            chk("stall_inst_DX", inst_DX, 32'h00C00193);
        end

        // Trap entry overrides the IF stall.
        PC_src_sel = 3'd5; handler_PC = 32'h00000100;
        step();
        chk("trap_PC_IF", PC_IF, 32'h00000100);
`ifdef VSCALE_FETCH_SKID_EN
        chk("trap_skid_valid", {31'd0, dut.skid_valid_r}, 32'd0);
        // Response captured during a DX stall is delivered once it releases.
        PC_src_sel = 3'd0; imem.imem_rdata = 32'h00A00113;
        step();
        stall_DX = 1'b0; imem.imem_wait = 1'b1; imem.imem_rdata = $urandom;
        step();
        chk("skid_inst_DX", inst_DX, 32'h00A00113);
        imem.imem_wait = 1'b0;
`endif

        // Randomized phase.
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 99) == 0);
            PC_src_sel = 3'($urandom_range(0, 7));
            branch_target = $urandom & 32'hFFFF_FFFC;
            jal_target    = $urandom & 32'hFFFF_FFFC;
            reg_target    = $urandom;
            handler_PC    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            stall_IF = ($urandom_range(0, 3) == 0);
            stall_DX = ($urandom_range(0, 3) == 0);
            kill_IF  = ($urandom_range(0, 4) == 0);
            kill_DX  = ($urandom_range(0, 4) == 0);
            imem.imem_wait  = ($urandom_range(0, 4) == 0);
            imem.imem_rdata = $urandom;
            step();
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
